// File: rtl/alu_unit_pkg.sv
// Shared global parameters for the ALU: widths, ROB id width and opcode encodings.
package alu_unit_pkg;

    localparam int XLEN           = 32;
    localparam int ROB_SIZE_WIDTH = 5;
    localparam int ALU_OP_WIDTH   = 4;
    localparam int SHAMT_WIDTH    = $clog2(XLEN);

    typedef logic [XLEN-1:0]           word_t;
    typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;
    typedef logic [ALU_OP_WIDTH-1:0]   alu_op_t;

    // Encodings 14 and 15 are unassigned and yield a zero result.
    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_SUB  = 4'd1;
    localparam alu_op_t ALU_AND  = 4'd2;
    localparam alu_op_t ALU_OR   = 4'd3;
    localparam alu_op_t ALU_XOR  = 4'd4;
    localparam alu_op_t ALU_SHL  = 4'd5;
    localparam alu_op_t ALU_SHR  = 4'd6;
    localparam alu_op_t ALU_SHRA = 4'd7;
    localparam alu_op_t ALU_EQ   = 4'd8;
    localparam alu_op_t ALU_NEQ  = 4'd9;
    localparam alu_op_t ALU_LT   = 4'd10;
    localparam alu_op_t ALU_LTU  = 4'd11;
    localparam alu_op_t ALU_GE   = 4'd12;
    localparam alu_op_t ALU_GEU  = 4'd13;

endpackage

// File: rtl/alu_unit_if.sv
// Issue/result bus between the reservation station (master) and the ALU (slave).
interface alu_unit_if;
    import alu_unit_pkg::*;

    logic    rs_ready;
    alu_op_t rs_op;
    word_t   rs_val1;
    word_t   rs_val2;
    rob_id_t rs_id;
    logic    alu_ready;
    word_t   alu_res;
    rob_id_t alu_id;

    modport master (
        output rs_ready, rs_op, rs_val1, rs_val2, rs_id,
        input  alu_ready, alu_res, alu_id
    );

    modport slave (
        input  rs_ready, rs_op, rs_val1, rs_val2, rs_id,
        output alu_ready, alu_res, alu_id
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: opcode, a, b -> result.
module alu_core
    import alu_unit_pkg::*;
(
    input  alu_op_t op,
    input  word_t   a,
    input  word_t   b,
    output word_t   result
);

    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   cmp;

    assign shamt = b[SHAMT_WIDTH-1:0];

    always_comb begin
        cmp = 1'b0;
        case (op)
            ALU_EQ:  cmp = (a == b);
            ALU_NEQ: cmp = (a != b);
            ALU_LT:  cmp = ($signed(a) <  $signed(b));
            ALU_LTU: cmp = (a <  b);
            ALU_GE:  cmp = ($signed(a) >= $signed(b));
            ALU_GEU: cmp = (a >= b);
            default: cmp = 1'b0;
        endcase
    end

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SHL:  result = a << shamt;
            ALU_SHR:  result = a >> shamt;
            ALU_SHRA: result = word_t'($signed(a) >>> shamt);
            ALU_EQ, ALU_NEQ, ALU_LT, ALU_LTU, ALU_GE, ALU_GEU:
                      result = {{(XLEN-1){1'b0}}, cmp};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// Single-cycle ALU issue stage: result/id/valid registers with flush and reset handling.
// Optional ALU_PERF_CNT_EN adds issued/dropped operation counters.
module alu_unit
    import alu_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    alu_unit_if.slave   bus
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [31:0] alu_issue_cnt,
    output logic [31:0] alu_drop_cnt
`endif
);

    word_t   core_res;
    logic    ready_reg, ready_next;
    word_t   res_reg,   res_next;
    rob_id_t id_reg,    id_next;

    alu_core u_core (
        .op     (bus.rs_op),
        .a      (bus.rs_val1),
        .b      (bus.rs_val2),
        .result (core_res)
    );

    // Result and id only move on an accepted op, so they hold across idle cycles and flushes.
    always_comb begin
        ready_next = ready_reg;
        res_next   = res_reg;
        id_next    = id_reg;
        if (rst) begin
            ready_next = 1'b0;
            res_next   = '0;
            id_next    = '0;
        end else if (flush) begin
            ready_next = 1'b0;
        end else begin
            ready_next = bus.rs_ready;
            if (bus.rs_ready) begin
                res_next = core_res;
                id_next  = bus.rs_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            ready_reg <= ready_next;
            res_reg   <= res_next;
            id_reg    <= id_next;
        end
    end

    assign bus.alu_ready = ready_reg;
    assign bus.alu_res   = res_reg;
    assign bus.alu_id    = id_reg;

`ifdef ALU_PERF_CNT_EN
    logic [31:0] issue_cnt_reg, issue_cnt_next;
    logic [31:0] drop_cnt_reg,  drop_cnt_next;

    // Counters survive flushes; only reset clears them.
    always_comb begin
        issue_cnt_next = issue_cnt_reg;
        drop_cnt_next  = drop_cnt_reg;
        if (rst) begin
            issue_cnt_next = '0;
            drop_cnt_next  = '0;
        end else if (bus.rs_ready) begin
            if (flush)
                drop_cnt_next  = drop_cnt_reg + 32'd1;
            else
                issue_cnt_next = issue_cnt_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            issue_cnt_reg <= issue_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    assign alu_issue_cnt = issue_cnt_reg;
    assign alu_drop_cnt  = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed corner cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_alu_unit;
    import alu_unit_pkg::*;

    logic clk = 1'b0;
    logic rst, rdy, flush;
    always #5 clk = ~clk;

    alu_unit_if bus();

`ifdef ALU_PERF_CNT_EN
    logic [31:0] alu_issue_cnt, alu_drop_cnt;
`endif

    alu_unit dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .flush         (flush),
        .bus           (bus)
`ifdef ALU_PERF_CNT_EN
        ,
        .alu_issue_cnt (alu_issue_cnt),
        .alu_drop_cnt  (alu_drop_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the arithmetic definitions; signed order via sign-bit flip.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] as, bs;
        sh = b[4:0];
        as = a ^ 32'h8000_0000;
        bs = b ^ 32'h8000_0000;
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a + ~b + 32'd1;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SHL:  return a * (32'd1 << sh);
            ALU_SHR:  return a / (32'd1 << sh);
            ALU_SHRA: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            ALU_EQ:   return (a == b) ? 32'd1 : 32'd0;
            ALU_NEQ:  return (a == b) ? 32'd0 : 32'd1;
            ALU_LT:   return (as < bs) ? 32'd1 : 32'd0;
            ALU_LTU:  return (a < b)   ? 32'd1 : 32'd0;
            ALU_GE:   return (as < bs) ? 32'd0 : 32'd1;
            ALU_GEU:  return (a < b)   ? 32'd0 : 32'd1;
            default:  return 32'd0;
        endcase
    endfunction

    // Expected outputs after each edge.
    logic        m_ready;
    logic [31:0] m_res;
    rob_id_t     m_id;
    logic [31:0] m_issue, m_drop;

    always @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                m_ready <= 1'b0;
                m_res   <= 32'd0;
                m_id    <= '0;
                m_issue <= 32'd0;
                m_drop  <= 32'd0;
            end else if (flush) begin
                m_ready <= 1'b0;
                if (bus.rs_ready) m_drop <= m_drop + 32'd1;
            end else begin
                m_ready <= bus.rs_ready;
                if (bus.rs_ready) begin
                    m_res   <= alu_ref(bus.rs_op, bus.rs_val1, bus.rs_val2);
                    m_id    <= bus.rs_id;
                    m_issue <= m_issue + 32'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_ready", {31'd0, bus.alu_ready}, {31'd0, m_ready});
            chk("model_res",   bus.alu_res, m_res);
            chk("model_id",    32'(bus.alu_id), 32'(m_id));
`ifdef ALU_PERF_CNT_EN
            chk("model_issue_cnt", alu_issue_cnt, m_issue);
            chk("model_drop_cnt",  alu_drop_cnt,  m_drop);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int id);
        bus.rs_ready = 1'b1;
        bus.rs_op    = op;
        bus.rs_val1  = a;
        bus.rs_val2  = b;
        bus.rs_id    = rob_id_t'(id);
    endtask

    task automatic idle();
        bus.rs_ready = 1'b0;
        bus.rs_op    = ALU_ADD;
        bus.rs_val1  = 32'd0;
        bus.rs_val2  = 32'd0;
        bus.rs_id    = '0;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [6];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_001F};
        if ($urandom_range(3) == 0)
            return specials[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        idle();

        // Pin the reference model on hand-computed values.
        chk("ref_add_wrap", alu_ref(ALU_ADD,  32'hFFFF_FFFF, 32'h1),  32'h0);
        chk("ref_shra",     alu_ref(ALU_SHRA, 32'h8000_0000, 32'h24), 32'hF800_0000);
        chk("ref_shr",      alu_ref(ALU_SHR,  32'h8000_0000, 32'h24), 32'h0800_0000);
        chk("ref_lt",       alu_ref(ALU_LT,   32'hFFFF_FFFF, 32'h1),  32'h1);
        chk("ref_ltu",      alu_ref(ALU_LTU,  32'hFFFF_FFFF, 32'h1),  32'h0);
        chk("ref_sub",      alu_ref(ALU_SUB,  32'h0, 32'h1),          32'hFFFF_FFFF);

        tick();
        check_en = 1'b1;
        chk("rst_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("rst_res",   bus.alu_res, 32'd0);
        chk("rst_id",    32'(bus.alu_id), 32'd0);
        rst = 1'b0;

        issue(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5);
        tick();
        chk("add_ready", {31'd0, bus.alu_ready}, 32'd1);
        chk("add_res",   bus.alu_res, 32'd0);
        chk("add_id",    32'(bus.alu_id), 32'd5);
        idle();
        tick();
        chk("idle_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("idle_id_hold", 32'(bus.alu_id), 32'd5);

        issue(ALU_SHRA, 32'h8000_0000, 32'h24, 1); tick();
        chk("shra_res", bus.alu_res, 32'hF800_0000);
        issue(ALU_SHR,  32'h8000_0000, 32'h24, 1); tick();
        chk("shr_res",  bus.alu_res, 32'h0800_0000);
        issue(ALU_LT,   32'hFFFF_FFFF, 32'h1, 2);  tick();
        chk("lt_res",   bus.alu_res, 32'h1);
        issue(ALU_LTU,  32'hFFFF_FFFF, 32'h1, 2);  tick();
        chk("ltu_res",  bus.alu_res, 32'h0);
        issue(ALU_GEU,  32'hFFFF_FFFF, 32'h1, 2);  tick();
        chk("geu_res",  bus.alu_res, 32'h1);
        issue(4'hE, 32'h5, 32'h6, 9);              tick();
        chk("undef_ready", {31'd0, bus.alu_ready}, 32'd1);
        chk("undef_res",   bus.alu_res, 32'h0);
        chk("undef_id",    32'(bus.alu_id), 32'd9);

        // Flush on a fresh reset: the op is dropped and counted as such.
        rst = 1'b1; idle(); tick(); rst = 1'b0;
        issue(ALU_ADD, 32'h1, 32'h2, 7); flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_ready", {31'd0, bus.alu_ready}, 32'd0);
`ifdef ALU_PERF_CNT_EN
        chk("flush_drop_cnt",  alu_drop_cnt,  32'd1);
        chk("flush_issue_cnt", alu_issue_cnt, 32'd0);
`endif

        // Stall: three frozen edges, then the op lands one cycle after rdy returns.
        issue(ALU_ADD, 32'd10, 32'd20, 3); rdy = 1'b0; flush = 1'b1; rst = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_ready", {31'd0, bus.alu_ready}, 32'd0);
            chk("stall_id",    32'(bus.alu_id), 32'd0);
        end
        rdy = 1'b1; flush = 1'b0; rst = 1'b0;
        tick();
        chk("resume_ready", {31'd0, bus.alu_ready}, 32'd1);
        chk("resume_res",   bus.alu_res, 32'd30);
        chk("resume_id",    32'(bus.alu_id), 32'd3);

        for (int i = 1; i <= 3; i++) begin
            issue(ALU_XOR, 32'hA5A5_0000, 32'(i), 3'(i) == 3'd2 ? 2 : i);
            tick();
            chk("b2b_ready", {31'd0, bus.alu_ready}, 32'd1);
            chk("b2b_id",    32'(bus.alu_id), 32'(i));
        end
        idle(); tick();
        chk("b2b_end_ready", {31'd0, bus.alu_ready}, 32'd0);

        issue(ALU_OR, 32'h1, 32'h2, 1); tick();
        chk("rstmid_id1", 32'(bus.alu_id), 32'd1);
        rst = 1'b1; issue(ALU_OR, 32'h1, 32'h2, 2); tick();
        chk("rstmid_ready2", {31'd0, bus.alu_ready}, 32'd0);
        rst = 1'b0; idle(); tick();
        chk("rstmid_ready3", {31'd0, bus.alu_ready}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(63) == 0);
            flush = ($urandom_range(15) == 0);
            rdy   = ($urandom_range(7) != 0);
            bus.rs_ready = ($urandom_range(9) < 7);
            bus.rs_op    = 4'($urandom_range(15));
            bus.rs_val1  = pick_operand();
            bus.rs_val2  = pick_operand();
            bus.rs_id    = rob_id_t'($urandom);
            tick();
        end

        rst = 1'b0; flush = 1'b0; rdy = 1'b1; idle();
        tick();
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
Constants, from the shared parameter header:
REQ-001 XLEN, 32, datapath width.
REQ-002 ROB_SIZE_WIDTH, ROB-defined, ROB id width.
REQ-003 ALU_OP_WIDTH, 4, ALU opcode width.

Ports:
REQ-004 clk  in  1  clock; rising-edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 rdy  in  1  global enable; low freezes all state.
REQ-007 flush  in  1  misprediction flush from ROB.
REQ-008 rs_ready  in  1  operation valid from reservation station.
REQ-009 rs_op  in  ALU_OP_WIDTH  ALU opcode.
REQ-010 rs_val1  in  XLEN  operand 1.
REQ-011 rs_val2  in  XLEN  operand 2 (register or immediate).
REQ-012 rs_id  in  ROB_SIZE_WIDTH  ROB id of the operation.
REQ-013 alu_ready  out  1  result valid; broadcast to RS and ROB.
REQ-014 alu_res  out  XLEN  result.
REQ-015 alu_id  out  ROB_SIZE_WIDTH  ROB id of the result.

Function
REQ-016 The block SHALL accept one operation per cycle with no backpressure (no ready/stall output); RS issue is never refused.
REQ-017 Latency SHALL be exactly 1 cycle: if rs_ready=1 at edge N (rdy=1, no rst, no flush), then alu_ready=1 with alu_res/alu_id valid from edge N until edge N+1.
REQ-018 alu_ready SHALL be 0 after any edge where rs_ready=0; alu_res/alu_id then hold their previous values.
REQ-019 Ops: ADD a+b; SUB a-b; AND, OR, XOR bitwise; SHL a<<b[4:0]; SHR logical a>>b[4:0]; SHRA arithmetic a>>>b[4:0].
REQ-020 Compares SHALL produce the zero-extended 1-bit result {31'b0,c}: EQ a==b; NEQ a!=b; LT signed a<b; LTU unsigned a<b; GE signed a>=b; GEU unsigned a>=b.
REQ-021 Arithmetic SHALL wrap modulo 2^XLEN; overflow is ignored and no flags are produced.
REQ-022 An undefined opcode SHALL produce alu_res=0 with alu_ready=1 and alu_id=rs_id.
REQ-023 At an edge with flush=1, the block SHALL set alu_ready to 0 regardless of rs_ready; the in-flight op is dropped.
REQ-024 Priority at an edge (rdy=1) SHALL be rst > flush > normal issue.
REQ-025 With rdy=0, no register SHALL change, including under rst or flush.
REQ-026 Back-to-back ops with the same rs_id SHALL each produce their own one-cycle result.

Reset
REQ-027 At an edge with rst=1 and rdy=1: alu_ready=0, alu_res=0, alu_id=0, and all counters (if present) SHALL be 0.
REQ-028 Reset asserted while an op is in flight SHALL drop the op; no result is broadcast.

Configuration
REQ-029 Macro ALU_PERF_CNT_EN SHALL, when defined, add the outputs alu_issue_cnt (out, 32; count of ops accepted) and alu_drop_cnt (out, 32; count of ops with rs_ready=1 dropped by flush).
REQ-030 With ALU_PERF_CNT_EN defined, the counters SHALL wrap at 2^32, hold under rdy=0, and clear on rst only (not on flush).
REQ-031 Without ALU_PERF_CNT_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-032 ALU opcode encodings (ALU_ADD…ALU_GEU), ALU_OP_WIDTH, XLEN and ROB_SIZE_WIDTH SHALL live in the shared global parameter header; the block SHALL NOT define local copies.
REQ-033 The combinational datapath SHALL be a sub-module alu_core (ops a, b -> result); alu_unit holds the valid/id/result registers, flush/reset handling and counters.

Verification
REQ-034 ADD 0xFFFFFFFF + 0x00000001, id=5 -> next cycle alu_ready=1, alu_res=0, alu_id=5; following cycle alu_ready=0.
REQ-035 SHRA a=0x80000000, b=0x00000024 -> alu_res=0xF8000000 (shift 4); SHR same operands -> 0x08000000.
REQ-036 LT a=0xFFFFFFFF, b=1 -> 1; LTU same operands -> 0; GEU same operands -> 1.
REQ-037 rs_ready=1 and flush=1 at the same edge -> alu_ready=0; with ALU_PERF_CNT_EN, alu_drop_cnt=1 and alu_issue_cnt=0.
REQ-038 Op issued while rdy=0 for 3 cycles -> outputs frozen; once rdy=1, result appears one cycle after the first sampled edge.
REQ-039 Three consecutive ops (ids 1,2,3) -> alu_ready held high 3 cycles with ids 1,2,3 in order; rst on the 2nd edge -> only id 1 is broadcast.
